// File: rtl/hndshk_arb_pkg.sv
// Shared types and constants for hndshk_tx_arbiter.
// Optional ack-wait timeout is enabled with `define HNDSHK_ARB_TIMEOUT_EN.
package hndshk_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ASSERT     = 2'd1,
        WAIT_DEACK = 2'd2
    } arb_state_t;

    localparam int unsigned TIMEOUT_CYC_MAX = 65535;
    localparam int unsigned TO_CNT_W        = $clog2(TIMEOUT_CYC_MAX + 1);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans req starting at pointer, returns a
// one-hot winner (all zero when no request is pending).
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] pointer,
    output logic [N_REQ-1:0] winner
);

    logic [PTR_W:0] w_sum;
    logic           w_found;

    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            // wrap pointer+offset back into 0..N_REQ-1 without a divider
            w_sum = {1'b0, pointer} + (PTR_W + 1)'(off);
            if (w_sum >= (PTR_W + 1)'(N_REQ)) begin
                w_sum = w_sum - (PTR_W + 1)'(N_REQ);
            end
            if (!w_found && req[w_sum[PTR_W-1:0]]) begin
                winner[w_sum[PTR_W-1:0]] = 1'b1;
                w_found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hndshk_tx_arbiter.sv
// Round-robin arbiter feeding a 4-phase req/ack handshake into another clock domain.
// Define HNDSHK_ARB_TIMEOUT_EN to abandon transfers whose ack never arrives.
module hndshk_tx_arbiter
    import hndshk_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic                    t_rdy,
    output logic [DATA_W-1:0]       t_data,
    input  logic                    r_ack,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("hndshk_tx_arbiter: N_REQ must be 2..8");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > TIMEOUT_CYC_MAX) begin : g_bad_timeout
        $error("hndshk_tx_arbiter: TIMEOUT_CYC must be 1..65535");
    end

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_ack_meta;
    logic              r_ack_s;
    logic [N_REQ-1:0]  r_grant;
    logic [N_REQ-1:0]  w_grant_nxt;
    logic              r_t_rdy;
    logic              w_t_rdy_nxt;
    logic [DATA_W-1:0] r_t_data;
    logic [DATA_W-1:0] w_t_data_nxt;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [N_REQ-1:0]  w_winner;
    logic [PTR_W-1:0]  w_win_idx;
    logic [DATA_W-1:0] w_win_data;
    logic [PTR_W-1:0]  w_ptr_adv;
    logic              w_capture;
`ifdef HNDSHK_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] r_cnt;
    logic [TO_CNT_W-1:0] w_cnt_nxt;
    logic [TO_CNT_W-1:0] w_cnt_inc;
    logic                r_to_err;
    logic                w_to_err_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= r_ack;
            r_ack_s    <= r_ack_meta;
        end
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req     (req),
        .pointer (r_ptr),
        .winner  (w_winner)
    );

    always_comb begin
        w_win_idx  = '0;
        w_win_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_winner[i]) begin
                w_win_idx  = PTR_W'(i);
                w_win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        w_ptr_adv = (w_win_idx == PTR_W'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = '0;
        w_t_rdy_nxt  = r_t_rdy;
        w_t_data_nxt = r_t_data;
        w_ptr_nxt    = r_ptr;
        w_capture    = 1'b0;
`ifdef HNDSHK_ARB_TIMEOUT_EN
        w_cnt_inc    = r_cnt + 1'b1;
        w_cnt_nxt    = r_cnt;
        w_to_err_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_capture = |req;
            end
            ASSERT: begin
`ifdef HNDSHK_ARB_TIMEOUT_EN
                w_cnt_nxt = w_cnt_inc;
`endif
                // ack is tested first so a same-cycle ack beats the timeout
                if (r_ack_s) begin
                    w_t_rdy_nxt  = 1'b0;
                    w_t_data_nxt = '0;
                    w_state_nxt  = WAIT_DEACK;
                end
`ifdef HNDSHK_ARB_TIMEOUT_EN
                else if (w_cnt_inc == TO_CNT_W'(TIMEOUT_CYC)) begin
                    w_t_rdy_nxt  = 1'b0;
                    w_t_data_nxt = '0;
                    w_to_err_nxt = 1'b1;
                    w_state_nxt  = WAIT_DEACK;
                end
`endif
            end
            WAIT_DEACK: begin
                if (!r_ack_s) begin
                    if (|req) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_capture) begin
            w_state_nxt  = ASSERT;
            w_grant_nxt  = w_winner;
            w_t_rdy_nxt  = 1'b1;
            w_t_data_nxt = w_win_data;
            w_ptr_nxt    = w_ptr_adv;
`ifdef HNDSHK_ARB_TIMEOUT_EN
            w_cnt_nxt    = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_t_rdy  <= 1'b0;
            r_t_data <= '0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_t_rdy  <= w_t_rdy_nxt;
            r_t_data <= w_t_data_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

`ifdef HNDSHK_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_to_err <= w_to_err_nxt;
        end
    end

    assign timeout_err = r_to_err;
`else
    assign timeout_err = 1'b0;
`endif

    assign grant  = r_grant;
    assign t_rdy  = r_t_rdy;
    assign t_data = r_t_data;
    assign busy   = (r_state != IDLE);

endmodule
